// File: rtl/ser_frame_tx.sv
// MSB-first parallel-to-serial frame transmitter with frame strobe and done pulse.
// Define SER_FRAME_TX_PARITY_EN to append an even-parity bit to every frame.
module ser_frame_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             sdo,
  output logic             sframe,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef SER_FRAME_TX_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd3;
  logic par_q;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;

  assign accept = load & ready;
  // The shift register is zero whenever no frame bit is on the line, so its MSB is sdo directly.
  assign sdo = sreg[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      sreg   <= '0;
      cnt    <= '0;
      ready  <= 1'b1;
      sframe <= 1'b0;
      done   <= 1'b0;
`ifdef SER_FRAME_TX_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state  <= S_SHIFT;
            sreg   <= data_in;
            cnt    <= CW'(WIDTH - 1);
            ready  <= 1'b0;
            sframe <= 1'b1;
`ifdef SER_FRAME_TX_PARITY_EN
            par_q  <= ^data_in;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (cnt == '0) begin
`ifdef SER_FRAME_TX_PARITY_EN
            // Parity rides out through the same MSB flop as the data bits.
            state <= S_PAR;
            sreg  <= {par_q, {(WIDTH-1){1'b0}}};
`else
            state  <= S_DONE;
            sreg   <= '0;
            ready  <= 1'b1;
            sframe <= 1'b0;
            done   <= 1'b1;
`endif
          end else begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
            cnt  <= cnt - 1'b1;
          end
        end
`ifdef SER_FRAME_TX_PARITY_EN
        S_PAR: begin
          state  <= S_DONE;
          sreg   <= '0;
          ready  <= 1'b1;
          sframe <= 1'b0;
          done   <= 1'b1;
        end
`endif
        default: begin
          state  <= S_IDLE;
          sreg   <= '0;
          ready  <= 1'b1;
          sframe <= 1'b0;
        end
      endcase
    end
  end

endmodule
